// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive pair: FSM encoding,
// parity modes and the default system clock frequency.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam int unsigned ParityNone = 0;
  localparam int unsigned ParityOdd  = 1;
  localparam int unsigned ParityEven = 2;

  localparam int unsigned ClkFreqDefault = 50_000_000;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs while enabled and flags the last cycle of each bit.
module uart_baud_gen #(
  parameter int unsigned BitCntMax = 5208
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (BitCntMax > 1) ? $clog2(BitCntMax) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BitCntMax - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = en && (cnt_q == CntLast);

  // Counter restarts at every bit boundary and parks at zero while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_send.sv
// UART transmitter: 8 data bits LSB first, optional parity, one stop bit.
// All line-side outputs are registered; the start bit begins the cycle after send_en.
module uart_send
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = ClkFreqDefault,
  parameter int unsigned UART_BOT = 9600,
  parameter int unsigned PARITY   = ParityNone
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       send_en,
  input  logic [7:0] send_data,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned BitCntMax = CLK_FREQ / UART_BOT;

  uart_state_e state_q;
  logic [7:0]  data_q;
  logic [2:0]  bit_idx_q;
  logic        bit_tick;
  logic        par_bit;

  uart_baud_gen #(
    .BitCntMax(BitCntMax)
  ) u_baud_gen (
    .clk  (sys_clk),
    .rst_n(sys_rst),
    .en   (tx_busy),
    .tick (bit_tick)
  );

  assign par_bit = (PARITY == ParityOdd) ? ~(^data_q) : (^data_q);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q   <= StIdle;
      data_q    <= '0;
      bit_idx_q <= '0;
      uart_tx   <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (send_en) begin
            state_q   <= StStart;
            data_q    <= send_data;
            bit_idx_q <= '0;
            uart_tx   <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end
        StStart: begin
          if (bit_tick) begin
            state_q <= StData;
            uart_tx <= data_q[0];
          end
        end
        StData: begin
          if (bit_tick) begin
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
              if (PARITY != ParityNone) begin
                state_q <= StParity;
                uart_tx <= par_bit;
              end else begin
                state_q <= StStop;
                uart_tx <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              uart_tx   <= data_q[bit_idx_q + 3'd1];
            end
          end
        end
        StParity: begin
          if (bit_tick) begin
            state_q <= StStop;
            uart_tx <= 1'b1;
          end
        end
        StStop: begin
          // Dropping busy here lets a request in the done cycle start the next frame.
          if (bit_tick) begin
            state_q <= StIdle;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          uart_tx <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_send.sv
// Self-checking bench for uart_send: three instances (no/odd/even parity) at 115200 baud,
// a line-decoding monitor fed from a scoreboard queue, plus corner-case sequences.
module tb_uart_send;
  import uart_pkg::*;

  localparam int unsigned ClkFreq = 50_000_000;
  localparam int unsigned Baud    = 115200;
  localparam int          BitLen  = 434;
  localparam int          HalfLen = 217;
  localparam int          DoneMax = 6000;

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic       par;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [2:0] send_en;
  logic [7:0] send_data;
  logic [2:0] tx_w;
  logic [2:0] busy_w;
  logic [2:0] done_w;
  logic [1:0] sel;
  logic       mon_en;
  logic       tx_s;
  logic       busy_s;
  logic       done_s;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  assign tx_s   = tx_w[sel];
  assign busy_s = busy_w[sel];
  assign done_s = done_w[sel];

  always #10 sys_clk = ~sys_clk;

  uart_send #(.CLK_FREQ(ClkFreq), .UART_BOT(Baud), .PARITY(ParityNone)) u_dut_none (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .send_en(send_en[0]), .send_data(send_data),
    .uart_tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
  );

  uart_send #(.CLK_FREQ(ClkFreq), .UART_BOT(Baud), .PARITY(ParityOdd)) u_dut_odd (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .send_en(send_en[1]), .send_data(send_data),
    .uart_tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
  );

  uart_send #(.CLK_FREQ(ClkFreq), .UART_BOT(Baud), .PARITY(ParityEven)) u_dut_even (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .send_en(send_en[2]), .send_data(send_data),
    .uart_tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One-cycle request on the selected instance; data is scrambled afterwards.
  task automatic send(input logic [7:0] d);
    send_data    = d;
    send_en[sel] = 1'b1;
    @(negedge sys_clk);
    send_en   = '0;
    send_data = 8'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_s && n < DoneMax) begin
      @(negedge sys_clk);
      n++;
    end
    check("done_timeout", 32'(n < DoneMax), 1);
  endtask

  // Decodes each frame at bit centres and checks exact tx_done timing.
  initial begin : monitor
    logic       tx_prev;
    logic [7:0] rx;
    logic       par;
    logic       stop;
    int         nb;
    exp_t       e;
    tx_prev = 1'b1;
    forever begin
      @(negedge sys_clk);
      if (mon_en && tx_prev && !tx_s) begin
        nb = (sel == 2'd0) ? 10 : 11;
        par = 1'b0;
        repeat (HalfLen) @(negedge sys_clk);
        check("start_bit", tx_s, 0);
        check("busy_mid", busy_s, 1);
        for (int i = 0; i < 8; i++) begin
          repeat (BitLen) @(negedge sys_clk);
          rx[i] = tx_s;
        end
        if (nb == 11) begin
          repeat (BitLen) @(negedge sys_clk);
          par = tx_s;
        end
        repeat (BitLen) @(negedge sys_clk);
        stop = tx_s;
        check("stop_bit", stop, 1);
        repeat (BitLen - HalfLen - 1) @(negedge sys_clk);
        check("done_early", done_s, 0);
        @(negedge sys_clk);
        check("done_at_frame_end", done_s, 1);
        check("frame_expected", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("data_byte", rx, e.data);
          if (nb == 11) check("parity_bit", par, e.par);
        end
      end
      tx_prev = tx_s;
    end
  end

  initial begin : main
    vec_t vecs[6];
    logic saw;
    vecs[0] = '{8'h55, 2'd0, 1'b0};
    vecs[1] = '{8'hA3, 2'd2, 1'b0};
    vecs[2] = '{8'hA3, 2'd1, 1'b1};
    vecs[3] = '{8'h00, 2'd0, 1'b0};
    vecs[4] = '{8'hFF, 2'd1, 1'b1};
    vecs[5] = '{8'h80, 2'd2, 1'b1};

    sys_rst   = 1'b0;
    send_en   = '0;
    send_data = '0;
    sel       = 2'd0;
    mon_en    = 1'b1;
    repeat (3) @(negedge sys_clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_tx", tx_w[d], 1);
      check("rst_busy", busy_w[d], 0);
      check("rst_done", done_w[d], 0);
    end
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);

    for (int v = 0; v < 6; v++) begin
      sel = vecs[v].mode;
      repeat (4) @(negedge sys_clk);
      sb_q.push_back('{vecs[v].data, vecs[v].par});
      send(vecs[v].data);
      check("first_start_cycle", tx_s, 0);
      wait_done();
      @(negedge sys_clk);
      check("idle_busy", busy_s, 0);
      check("idle_tx", tx_s, 1);
    end

    // Request during DATA must be ignored.
    sel = 2'd0;
    repeat (4) @(negedge sys_clk);
    sb_q.push_back('{8'h55, 1'b0});
    send(8'h55);
    repeat (2000) @(negedge sys_clk);
    send_data  = 8'h0F;
    send_en[0] = 1'b1;
    @(negedge sys_clk);
    send_en = '0;
    check("busy_after_ignored", busy_s, 1);
    wait_done();
    saw = 1'b0;
    repeat (50) begin
      @(negedge sys_clk);
      if (busy_s || !tx_s) saw = 1'b1;
    end
    check("no_second_frame", saw, 0);

    // Back-to-back: request in the tx_done cycle starts the next frame immediately.
    repeat (4) @(negedge sys_clk);
    sb_q.push_back('{8'h12, 1'b0});
    send(8'h12);
    wait_done();
    sb_q.push_back('{8'h34, 1'b0});
    send(8'h34);
    check("b2b_start", tx_s, 0);
    check("b2b_busy", busy_s, 1);
    wait_done();

    // Reset mid-frame aborts the frame without a done pulse.
    @(negedge sys_clk);
    mon_en = 1'b0;
    repeat (4) @(negedge sys_clk);
    send(8'h55);
    repeat (1000) @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    check("abort_tx", tx_s, 1);
    check("abort_busy", busy_s, 0);
    check("abort_done", done_s, 0);
    saw = 1'b0;
    repeat (3) begin
      @(negedge sys_clk);
      if (done_s) saw = 1'b1;
    end
    sys_rst = 1'b1;
    repeat (20) begin
      @(negedge sys_clk);
      if (done_s || busy_s || !tx_s) saw = 1'b1;
    end
    check("abort_quiet", saw, 0);
    mon_en = 1'b1;
    repeat (4) @(negedge sys_clk);
    sb_q.push_back('{8'hC6, 1'b0});
    send(8'hC6);
    check("post_rst_start", tx_s, 0);
    wait_done();
    repeat (4) @(negedge sys_clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_send.md
UART_SEND -- requirements
Module: uart_send

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, meaning the sys_clk frequency in Hz.
REQ-002 The block SHALL have parameter UART_BOT, default 9600, meaning the line baud rate.
REQ-003 The block SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have port sys_clk, input, 1 bit: system clock, 50 MHz nominal.
REQ-006 The block SHALL have port sys_rst, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port send_en, input, 1 bit: single-cycle transmit request.
REQ-008 The block SHALL have port send_data, input, 8 bits: byte to transmit, sampled with send_en.
REQ-009 The block SHALL have port uart_tx, output, 1 bit: serial line, idle high.
REQ-010 The block SHALL have port tx_busy, output, 1 bit: frame in progress.
REQ-011 The block SHALL have port tx_done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-012 Bit period SHALL be BIT_CNT_MAX = CLK_FREQ/UART_BOT cycles (integer division; 5208 at defaults); counter width = ceil(log2(BIT_CNT_MAX)).
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-014 Transition IDLE->START SHALL occur when send_en=1 in IDLE; send_data is latched into a shift register in that cycle.
REQ-015 START->DATA SHALL occur after BIT_CNT_MAX cycles with uart_tx=0.
REQ-016 DATA SHALL drive 8 bits LSB first, each for BIT_CNT_MAX cycles; a 3-bit index counts 0..7; after bit 7 the FSM goes to PARITY if PARITY!=0, else to STOP.
REQ-017 PARITY SHALL drive XOR of the latched byte (even) or its complement (odd) for BIT_CNT_MAX cycles, then go to STOP.
REQ-018 STOP SHALL drive uart_tx=1 for BIT_CNT_MAX cycles, then go to IDLE.
REQ-019 uart_tx SHALL be registered; the first start-bit cycle is the cycle after send_en is sampled (latency 1).
REQ-020 tx_busy SHALL be 1 in every state except IDLE.
REQ-021 tx_done SHALL pulse for exactly one cycle, the first IDLE cycle after STOP completes.
REQ-022 Frame length SHALL be 10*BIT_CNT_MAX cycles (11*BIT_CNT_MAX with parity).
REQ-023 send_en while tx_busy=1 SHALL be ignored; the frame in progress and the latched byte are unchanged.
REQ-024 send_en in the tx_done cycle SHALL be accepted (back-to-back frames, no extra idle bit time).
REQ-025 The bit counter SHALL reset to 0 at each bit boundary and hold 0 in IDLE.
REQ-026 send_data changes outside the send_en cycle SHALL NOT affect the line.

Reset
REQ-027 On sys_rst=0, asynchronously: state=IDLE, uart_tx=1, tx_busy=0, tx_done=0, counters=0, shift register=0.
REQ-028 Reset mid-frame SHALL abort the frame; uart_tx returns high immediately, no tx_done is issued, and the next send_en after release starts a full new frame.

Structure
REQ-029 Shared package uart_pkg SHALL hold the FSM state encoding, the PARITY encodings, and the CLK_FREQ default; uart_recv and uart_send both use it.
REQ-030 Sub-module uart_baud_gen (bit counter plus end-of-bit tick, enabled by tx_busy) SHALL be the single natural sub-module.

Verification (CLK_FREQ=50_000_000, UART_BOT=115200 -> BIT_CNT_MAX=434)
REQ-031 Scenario: send_en with 0x55, PARITY=0 -> line 0,1,0,1,0,1,0,1,0,1, 434 cycles each, tx_done 4340 cycles after the first start cycle.
REQ-032 Scenario: 0xA3, PARITY=2 -> data bits 1,1,0,0,0,1,0,1, parity bit 0, stop bit 1, frame 4774 cycles.
REQ-033 Scenario: 0xA3, PARITY=1 -> parity bit 1; all other bits as in REQ-032.
REQ-034 Scenario: send_en with 0x0F during DATA of 0x55 -> 0x55 frame unaltered, no second frame.
REQ-035 Scenario: send 0x12, then send_en with 0x34 in the tx_done cycle -> next start bit in the following cycle; a uart_recv loopback returns 0x12, then 0x34.
REQ-036 Scenario: sys_rst low at cycle 1000 of a frame -> uart_tx=1, tx_busy=0 within the same cycle, no tx_done.
